m31_sbox_pow5: RTL and testbench

//  Poseidon2 S-box over M31: y = x^5 mod P (P = 2^31-1).

---
 rtl/m31_sbox_pow5.sv | 210 +++++++++++++++++++++
 tb/tb_m31_sbox_pow5.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m31_sbox_pow5.sv
// m31_sbox_pow5: Poseidon2 S-box over the Mersenne-31 field, y = x^5 mod (2^31-1).
// Three chained M31 multipliers (x^2, x^4, x^5) form a fully pipelined datapath.
// A tag rides alongside each element. A credit-controlled output FIFO absorbs
// downstream stalls, so the pipeline itself never needs to stop.

// m31_mul: four-stage modular multiplier, p = a*b mod (2^31-1).
// Inputs are captured at the first edge. The reduced product is available after
// the fourth edge. The block has no reset because it has no control state.
module m31_mul (
    input  logic        clk,
    input  logic [30:0] a,
    input  logic [30:0] b,
    output logic [30:0] p
);
    localparam logic [30:0] P = 31'h7FFF_FFFF;

    logic [30:0] a_q;
    logic [30:0] b_q;
    logic [61:0] prod_q;
    logic [31:0] sum_q;
    logic [30:0] fold;

    // Final fold: the carry out of (hi + lo) re-enters at weight 1 because 2^31 == 1 mod P.
    // The result is at most P, so it never overflows 31 bits.
    always_comb begin
        fold = 31'(sum_q[31]) + sum_q[30:0];
    end

    // Capture, multiply, first fold, then canonicalise (P maps to 0).
    // NOTE: sequential state uses non-blocking '<=' so every stage samples the previous stage's old value.
    // NOTE: pure datapath registers are not reset; stale contents are harmless because validity travels separately.
    always_ff @(posedge clk) begin
        a_q    <= a;
        b_q    <= b;
        prod_q <= 62'(a_q) * 62'(b_q);
        sum_q  <= 32'(prod_q[61:31]) + 32'(prod_q[30:0]);
        p      <= (fold == P) ? '0 : fold;
    end
endmodule

module m31_sbox_pow5 #(
    parameter int unsigned TAG_W      = 8,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [30:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [30:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // The pipeline spans 15 stages from accept to FIFO write.
    localparam int PIPE  = 15;
    // This is the delay of x needed to meet x^4 at the input of mul3.
    localparam int DLY   = 10;

    typedef struct packed {
        logic [30:0]      data;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // Handshake events
    logic accept;
    logic pop;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // ---------------------------------------------------------------- credits
    // Credits count FIFO slots that are not yet claimed by an in-flight or buffered element.
    logic [CNT_W-1:0] credit;
    logic [CNT_W-1:0] credit_nxt;

    // An accept claims a slot and a pop returns one. When both occur, the count is unchanged.
    // NOTE: every always_comb output gets a default first so that no path infers a latch.
    always_comb begin
        credit_nxt = credit;
        unique case ({accept, pop})
            2'b10:   credit_nxt = credit - CNT_W'(1);
            2'b01:   credit_nxt = credit + CNT_W'(1);
            default: credit_nxt = credit;
        endcase
    end

    // in_ready is registered from the next credit value, so it falls on the edge that uses the last slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit   <= CNT_W'(FIFO_DEPTH);
            in_ready <= 1'b0;
        end else begin
            credit   <= credit_nxt;
            in_ready <= (credit_nxt != '0);
        end
    end

    // --------------------------------------------------------------- datapath
    logic [30:0]      x_q;
    logic [30:0]      x2_q;
    logic [30:0]      x4_q;
    logic [30:0]      x_dly [DLY];
    logic [30:0]      mul1_p;
    logic [30:0]      mul2_p;
    logic [30:0]      mul3_p;
    logic [PIPE-1:0]  v_pipe;
    logic [TAG_W-1:0] tag_pipe [PIPE];

    // x^2 lands at edge A+4.
    m31_mul u_mul1 (
        .clk (clk),
        .a   (x_q),
        .b   (x_q),
        .p   (mul1_p)
    );

    // x^4 lands at edge A+9.
    m31_mul u_mul2 (
        .clk (clk),
        .a   (x2_q),
        .b   (x2_q),
        .p   (mul2_p)
    );

    // x^5 lands at edge A+14.
    m31_mul u_mul3 (
        .clk (clk),
        .a   (x4_q),
        .b   (x_dly[DLY-1]),
        .p   (mul3_p)
    );

    // Capture input at edge A, register between multipliers, delay x by 10 and carry tags alongside.
    always_ff @(posedge clk) begin
        x_q         <= in_data;
        x2_q        <= mul1_p;
        x4_q        <= mul2_p;
        x_dly[0]    <= x_q;
        tag_pipe[0] <= in_tag;
        for (int i = 1; i < DLY; i++) begin
            x_dly[i] <= x_dly[i-1];
        end
        for (int i = 1; i < PIPE; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Valid bits are the only pipeline state that needs a reset. Clearing them discards in-flight elements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_pipe <= '0;
        end else begin
            v_pipe <= {v_pipe[PIPE-2:0], accept};
        end
    end

    // ------------------------------------------------------------ output FIFO
    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    entry_t           head;

    assign wr_en = v_pipe[PIPE-1];
    assign head  = mem[rd_ptr];

    // Storage write at edge A+15. Credit flow control guarantees a free slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{data: mul3_p, tag: tag_pipe[PIPE-1]};
        end
    end

    // Pointers wrap naturally at the power-of-two depth. Occupancy tracks writes minus pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // First-word-fall-through head. Outputs are forced to zero when empty so they read 0 in reset.
    always_comb begin
        out_valid = (count != '0);
        out_data  = '0;
        out_tag   = '0;
        if (out_valid) begin
            out_data = head.data;
            out_tag  = head.tag;
        end
    end
endmodule

// File: tb/tb_m31_sbox_pow5.sv
// Self-checking bench for m31_sbox_pow5, using directed known values, random traffic against a
// queue-based reference model, backpressure, and reset during operation.
module tb_m31_sbox_pow5;
    localparam int          DEPTH = 32;
    localparam int          LAT   = 16;
    localparam logic [30:0] P     = 31'h7FFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [30:0] in_data;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [30:0] out_data;
    logic [7:0]  out_tag;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [30:0] data;
        logic [7:0]  tag;
        int          rdy;
    } exp_t;

    exp_t q[$];

    m31_sbox_pow5 #(.TAG_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Non-canonical input is never driven.
    always @(posedge clk) begin
        if (in_valid) assert (in_data != P);
    end

    // FIFO overflow watch: a write while full without a pop would lose data.
    always @(negedge clk) begin
        if (rst_n && dut.wr_en && !dut.pop) begin
            checks++;
            if (dut.count >= DEPTH) begin
                failures++;
                $display("FAIL fifo_overflow count=%0d at cycle %0d", dut.count, cyc);
            end
        end
    end

    // Reference: modular exponentiation with plain integer arithmetic.
    function automatic logic [30:0] pow5(input logic [30:0] x);
        longint unsigned p, a, a2, a4, a5;
        p  = 64'h7FFF_FFFF;
        a  = 64'(x);
        a2 = (a * a) % p;
        a4 = (a2 * a2) % p;
        a5 = (a4 * a) % p;
        return 31'(a5);
    endfunction

    function automatic logic [30:0] rand_x();
        return 31'($urandom % 32'h7FFF_FFFF);
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        if (out_tag !== '0) begin failures++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL release_in_ready_early got=%b want=0", in_ready); end
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b want=0", out_valid); end
    endtask

    // Single elements with constants derived by hand, with the latency measured from the accept.
    task automatic test_known_values();
        logic [30:0] xs  [7] = '{31'd0, 31'd1, 31'd2, 31'd3, 31'h7FFF_FFFE, 31'd128, 31'h4000_0000};
        logic [30:0] ys  [7] = '{31'd0, 31'd1, 31'd32, 31'd243, 31'h7FFF_FFFE, 31'd16, 31'h0400_0000};
        int c0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL known_in_ready[%0d] got=%b want=1", i, in_ready); end
            in_valid = 1'b1;
            in_data  = xs[i];
            in_tag   = 8'(8'h10 + i);
            c0       = cyc;
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = rand_x();
            in_tag   = 8'($urandom);
            while (!out_valid && (cyc - c0) < 40) @(negedge clk);
            checks += 4;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL known_timeout[%0d] no output within 40 cycles", i); end
            if (cyc - c0 != LAT) begin failures++; $display("FAIL known_latency[%0d] got=%0d want=%0d", i, cyc - c0, LAT); end
            if (out_data !== ys[i]) begin failures++; $display("FAIL known_data[%0d] x=%h got=%h want=%h", i, xs[i], out_data, ys[i]); end
            if (out_tag !== 8'(8'h10 + i)) begin failures++; $display("FAIL known_tag[%0d] got=%h want=%h", i, out_tag, 8'(8'h10 + i)); end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL known_single[%0d] extra output got=%b want=0", i, out_valid); end
        end
    endtask

    // Random traffic against the queue model. Each queue entry holds its value, tag and first visible cycle.
    task automatic test_traffic(input string name, input int n, input int in_pct, input int out_pct,
                                input bit expect_ready_high, input int budget);
        int acc_n = 0;
        int pop_n = 0;
        int ready_drops = 0;
        bit exp_v;
        bit acc;
        bit pop;
        for (int cy = 0; cy < budget && (acc_n < n || q.size() != 0); cy++) begin
            @(negedge clk);
            exp_v = (q.size() != 0) && (q[0].rdy <= cyc);
            checks += 2;
            if (out_valid !== exp_v) begin failures++; $display("FAIL %s_out_valid cycle=%0d got=%b want=%b", name, cyc, out_valid, exp_v); end
            if (in_ready !== (q.size() < DEPTH)) begin failures++; $display("FAIL %s_in_ready cycle=%0d got=%b want=%b", name, cyc, in_ready, q.size() < DEPTH); end
            if (exp_v) begin
                checks++;
                if (out_data !== q[0].data || out_tag !== q[0].tag) begin
                    failures++;
                    $display("FAIL %s_head cycle=%0d got=%h/%h want=%h/%h", name, cyc, out_data, out_tag, q[0].data, q[0].tag);
                end
            end
            if (acc_n < n && !in_ready) ready_drops++;
            in_valid  = (acc_n < n) && ($urandom_range(0, 99) < in_pct);
            in_data   = rand_x();
            in_tag    = 8'($urandom);
            out_ready = ($urandom_range(0, 99) < out_pct);
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                void'(q.pop_front());
                pop_n++;
            end
            if (acc) begin
                q.push_back('{data: pow5(in_data), tag: in_tag, rdy: cyc + LAT});
                acc_n++;
            end
            assert (q.size() <= DEPTH);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks += 3;
        if (acc_n != n) begin failures++; $display("FAIL %s_accepts got=%0d want=%0d", name, acc_n, n); end
        if (pop_n != n) begin failures++; $display("FAIL %s_outputs got=%0d want=%0d", name, pop_n, n); end
        if (q.size() != 0) begin failures++; $display("FAIL %s_leftover got=%0d want=0", name, q.size()); end
        if (expect_ready_high) begin
            checks++;
            if (ready_drops != 0) begin failures++; $display("FAIL %s_ready_high drops got=%0d want=0", name, ready_drops); end
        end
    endtask

    // Stall the output, fill until credits run out, then drain in order.
    task automatic test_backpressure(input string name);
        int acc_n = 0;
        int pop_n = 0;
        int first_pop = -1;
        bit exp_v;
        bit pop;
        out_ready = 1'b0;
        for (int cy = 0; cy < 60; cy++) begin
            @(negedge clk);
            exp_v = (q.size() != 0) && (q[0].rdy <= cyc);
            checks += 2;
            if (out_valid !== exp_v) begin failures++; $display("FAIL %s_fill_valid cycle=%0d got=%b want=%b", name, cyc, out_valid, exp_v); end
            if (in_ready !== (q.size() < DEPTH)) begin failures++; $display("FAIL %s_fill_ready cycle=%0d got=%b want=%b", name, cyc, in_ready, q.size() < DEPTH); end
            in_valid = 1'b1;
            in_data  = rand_x();
            in_tag   = 8'($urandom);
            if (in_ready) begin
                q.push_back('{data: pow5(in_data), tag: in_tag, rdy: cyc + LAT});
                acc_n++;
            end
        end
        for (int cy = 0; cy < 80 && q.size() != 0; cy++) begin
            @(negedge clk);
            if (cy == 0) begin
                checks += 2;
                if (acc_n != DEPTH) begin failures++; $display("FAIL %s_accepts got=%0d want=%0d", name, acc_n, DEPTH); end
                if (in_ready !== 1'b0) begin failures++; $display("FAIL %s_full_ready got=%b want=0", name, in_ready); end
            end
            if (first_pop >= 0 && cyc == first_pop + 1) begin
                checks++;
                if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_ready_return got=%b want=1", name, in_ready); end
            end
            exp_v = (q[0].rdy <= cyc);
            checks += 2;
            if (out_valid !== exp_v) begin failures++; $display("FAIL %s_drain_valid cycle=%0d got=%b want=%b", name, cyc, out_valid, exp_v); end
            if (exp_v && (out_data !== q[0].data || out_tag !== q[0].tag)) begin
                failures++;
                $display("FAIL %s_drain_head cycle=%0d got=%h/%h want=%h/%h", name, cyc, out_data, out_tag, q[0].data, q[0].tag);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            pop = out_valid && out_ready;
            if (pop) begin
                if (first_pop < 0) first_pop = cyc;
                void'(q.pop_front());
                pop_n++;
            end
        end
        @(negedge clk);
        checks += 2;
        if (pop_n != DEPTH) begin failures++; $display("FAIL %s_drained got=%0d want=%0d", name, pop_n, DEPTH); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_empty got=%b want=0", name, out_valid); end
    endtask

    // Reset with 10 elements in the pipe and 5 in the FIFO, then confirm nothing stale emerges.
    task automatic test_reset_mid();
        int stale = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_fill_ready[%0d] got=%b want=1", i, in_ready); end
            in_valid = 1'b1;
            in_data  = rand_x();
            in_tag   = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_buffered got=%b want=1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got=%b want=0", in_ready); end
        if (out_data !== '0) begin failures++; $display("FAIL mid_reset_data got=%h want=0", out_data); end
        if (out_tag !== '0) begin failures++; $display("FAIL mid_reset_tag got=%h want=0", out_tag); end
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_release_ready got=%b want=1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin failures++; $display("FAIL mid_stale_outputs got=%0d want=0", stale); end
    endtask

    initial begin
        test_reset();
        test_known_values();
        test_traffic("b2b", 1000, 100, 100, 1'b1, 3000);
        test_backpressure("bp");
        test_traffic("rand30", 300, 60, 30, 1'b0, 6000);
        test_reset_mid();
        test_backpressure("bp_after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
